dmem_arbiter: RTL

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arb_pkg.sv | 25 ++
 rtl/dmem_arbiter_if.sv | 33 +++
 rtl/dmem_rr_pick.sv | 19 +
 rtl/dmem_arbiter.sv | 137 +++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types, address map and decode for the data-memory arbiter.
// Holds the FSM state encoding, the RAM_TOP default and the MMIO register addresses.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } arb_state_e;

  localparam logic [31:0] RAM_TOP_DEFAULT = 32'h0000_07ff;

  localparam logic [31:0] MMIO_ADDR0 = 32'h4000_0000;
  localparam logic [31:0] MMIO_ADDR1 = 32'h4000_0004;
  localparam logic [31:0] MMIO_ADDR2 = 32'h4000_0008;
  localparam logic [31:0] MMIO_ADDR3 = 32'h4000_0010;

  // An address is mapped when it falls inside RAM or hits one of the MMIO registers.
  function automatic logic addr_mapped(input logic [31:0] addr, input logic [31:0] ram_top);
    return (addr <= ram_top) ||
           (addr == MMIO_ADDR0) || (addr == MMIO_ADDR1) ||
           (addr == MMIO_ADDR2) || (addr == MMIO_ADDR3);
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of the two requester ports, the shared response and the memory-side signals.
// slave = arbiter view, master = requesters plus memory model view.
interface dmem_arbiter_if;

  logic        p0_req,    p1_req;
  logic        p0_we,     p1_we;
  logic [31:0] p0_addr,   p1_addr;
  logic [31:0] p0_wdata,  p1_wdata;
  logic        p0_gnt,    p1_gnt;
  logic        p0_rvalid, p1_rvalid;
  logic [31:0] rdata;
  logic        err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_rdata;

  modport slave (
    input  p0_req, p1_req, p0_we, p1_we, p0_addr, p1_addr, p0_wdata, p1_wdata,
    input  mem_rdata,
    output p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, rdata, err,
    output mem_addr, mem_wdata, mem_read, mem_write
  );

  modport master (
    output p0_req, p1_req, p0_we, p1_we, p0_addr, p1_addr, p0_wdata, p1_wdata,
    output mem_rdata,
    input  p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, rdata, err,
    input  mem_addr, mem_wdata, mem_read, mem_write
  );

endinterface

// File: rtl/dmem_rr_pick.sv
// Two-way round-robin picker: on a tie the port not granted last wins, a lone requester always wins.
// Purely combinational; win_o is the winning port index and is meaningful only when any_o is high.
module dmem_rr_pick (
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic       any_o,
  output logic       win_o
);

  always_comb begin
    any_o = |req_i;
    if (&req_i) begin
      win_o = ~last_i;
    end else begin
      win_o = req_i[1];
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates CPU (port 0) and DMA (port 1) onto one data memory: IDLE -> ACCESS -> RESP, one access per 3 cycles.
// Define DMEM_ARB_FIXED_PRIO_EN to make port 0 win every tie instead of round-robin.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter logic [31:0] RAM_TOP = RAM_TOP_DEFAULT
) (
  input  logic           clk,
  input  logic           reset,
  dmem_arbiter_if.slave  bus
);

  arb_state_e  state_q, state_d;
  logic        win_q, win_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [1:0]  gnt_q, gnt_d;
  logic [1:0]  rvalid_q, rvalid_d;

  logic        pick_last;
  logic        any_req;
  logic        pick_win;
  logic        mapped;
  logic        in_access;
  logic        accept;

  assign accept = (state_q == ST_IDLE) && any_req;

`ifdef DMEM_ARB_FIXED_PRIO_EN
  // Pretending port 1 was always granted last turns the picker into fixed port-0 priority.
  assign pick_last = 1'b1;
`else
  logic last_q, last_d;

  assign last_d = accept ? pick_win : last_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

  assign pick_last = last_q;
`endif

  dmem_rr_pick u_pick (
    .req_i  ({bus.p1_req, bus.p0_req}),
    .last_i (pick_last),
    .any_o  (any_req),
    .win_o  (pick_win)
  );

  assign mapped    = addr_mapped(addr_q, RAM_TOP);
  assign in_access = (state_q == ST_ACCESS);

  always_comb begin
    state_d  = state_q;
    win_d    = win_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    gnt_d    = 2'b00;
    rvalid_d = 2'b00;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d         = ST_ACCESS;
          win_d           = pick_win;
          gnt_d[pick_win] = 1'b1;
          we_d            = pick_win ? bus.p1_we    : bus.p0_we;
          addr_d          = pick_win ? bus.p1_addr  : bus.p0_addr;
          wdata_d         = pick_win ? bus.p1_wdata : bus.p0_wdata;
        end
      end
      ST_ACCESS: begin
        state_d         = ST_RESP;
        rvalid_d[win_q] = 1'b1;
        rdata_d         = (!we_q && mapped) ? bus.mem_rdata : 32'h0;
        err_d           = ~mapped;
      end
      ST_RESP: begin
        // Response fields are cleared so they only ever show alongside rvalid.
        state_d = ST_IDLE;
        rdata_d = 32'h0;
        err_d   = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      win_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      rdata_q  <= 32'h0;
      err_q    <= 1'b0;
      gnt_q    <= 2'b00;
      rvalid_q <= 2'b00;
    end else begin
      state_q  <= state_d;
      win_q    <= win_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      gnt_q    <= gnt_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign bus.p0_gnt    = gnt_q[0];
  assign bus.p1_gnt    = gnt_q[1];
  assign bus.p0_rvalid = rvalid_q[0];
  assign bus.p1_rvalid = rvalid_q[1];
  assign bus.rdata     = rdata_q;
  assign bus.err       = err_q;

  assign bus.mem_addr  = in_access ? addr_q  : 32'h0;
  assign bus.mem_wdata = in_access ? wdata_q : 32'h0;
  assign bus.mem_read  = in_access && !we_q && mapped;
  assign bus.mem_write = in_access &&  we_q && mapped;

endmodule
